// File: rtl/bcd_mod_counter.sv
// Modulo-N up/down counter with registered BCD digit outputs and carry/borrow pulses.
// Define BCD_COUNTER_LOAD_EN to add the parallel BCD load port (load, load_low, load_high).
module bcd_mod_counter #(
    parameter int MODULUS = 60,
    parameter int INIT    = 0
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       up,
`ifdef BCD_COUNTER_LOAD_EN
    input  logic       load,
    input  logic [3:0] load_low,
    input  logic [3:0] load_high,
`endif
    output logic [3:0] low,
    output logic [3:0] high,
    output logic       co,
    output logic       bo,
    output logic       tc
);

    localparam logic [6:0] LAST_C   = 7'(MODULUS - 1);
    localparam logic [6:0] INIT_C   = 7'(INIT);
    localparam logic [3:0] INIT_LO  = 4'(INIT % 10);
    localparam logic [3:0] INIT_HI  = 4'(INIT / 10);

    logic [6:0] count_q, count_d;
    logic [3:0] low_q, low_d;
    logic [3:0] high_q, high_d;
    logic       co_q, co_d;
    logic       bo_q, bo_d;

`ifdef BCD_COUNTER_LOAD_EN
    logic [6:0] loadVal;
    logic       loadOk;

    // Out-of-range digits or values at/above the modulus collapse to zero.
    always_comb begin
        loadVal = 7'(load_high) * 7'd10 + 7'(load_low);
        loadOk  = (load_low <= 4'd9) && (load_high <= 4'd9) && (loadVal <= LAST_C);
    end
`endif

    always_comb begin
        count_d = count_q;
        co_d    = 1'b0;
        bo_d    = 1'b0;
        if (clr) begin
            count_d = 7'd0;
`ifdef BCD_COUNTER_LOAD_EN
        end else if (load) begin
            count_d = loadOk ? loadVal : 7'd0;
`endif
        end else if (en) begin
            if (up) begin
                if (count_q == LAST_C) begin
                    count_d = 7'd0;
                    co_d    = 1'b1;
                end else begin
                    count_d = count_q + 7'd1;
                end
            end else begin
                if (count_q == 7'd0) begin
                    count_d = LAST_C;
                    bo_d    = 1'b1;
                end else begin
                    count_d = count_q - 7'd1;
                end
            end
        end
        // Digits are registered alongside the count so they never lag it.
        low_d  = 4'(count_d % 7'd10);
        high_d = 4'(count_d / 7'd10);
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            count_q <= INIT_C;
            low_q   <= INIT_LO;
            high_q  <= INIT_HI;
            co_q    <= 1'b0;
            bo_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            low_q   <= low_d;
            high_q  <= high_d;
            co_q    <= co_d;
            bo_q    <= bo_d;
        end
    end

    assign low  = low_q;
    assign high = high_q;
    assign co   = co_q;
    assign bo   = bo_q;
    assign tc   = en & ((up & (count_q == LAST_C)) | (~up & (count_q == 7'd0)));

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter: vector table on a mod-60 instance plus
// hand sequences for full cycles, INIT hold (mod-24) and mod-100 wrap/toggling.
module tb_bcd_mod_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]      rstV, clrV, enV, upV;
    logic [2:0][3:0] lowV, highV;
    logic [2:0]      coV, boV, tcV;

`ifdef BCD_COUNTER_LOAD_EN
    logic       load0;
    logic [3:0] loadLow0, loadHigh0;
`endif

    int checks   = 0;
    int failures = 0;
    int cnt;

    bcd_mod_counter #(.MODULUS(60), .INIT(0)) u60 (
        .clkin(clk), .rst(rstV[0]), .clr(clrV[0]), .en(enV[0]), .up(upV[0]),
`ifdef BCD_COUNTER_LOAD_EN
        .load(load0), .load_low(loadLow0), .load_high(loadHigh0),
`endif
        .low(lowV[0]), .high(highV[0]), .co(coV[0]), .bo(boV[0]), .tc(tcV[0])
    );

    bcd_mod_counter #(.MODULUS(24), .INIT(12)) u24 (
        .clkin(clk), .rst(rstV[1]), .clr(clrV[1]), .en(enV[1]), .up(upV[1]),
`ifdef BCD_COUNTER_LOAD_EN
        .load(1'b0), .load_low(4'd0), .load_high(4'd0),
`endif
        .low(lowV[1]), .high(highV[1]), .co(coV[1]), .bo(boV[1]), .tc(tcV[1])
    );

    bcd_mod_counter #(.MODULUS(100), .INIT(0)) u100 (
        .clkin(clk), .rst(rstV[2]), .clr(clrV[2]), .en(enV[2]), .up(upV[2]),
`ifdef BCD_COUNTER_LOAD_EN
        .load(1'b0), .load_low(4'd0), .load_high(4'd0),
`endif
        .low(lowV[2]), .high(highV[2]), .co(coV[2]), .bo(boV[2]), .tc(tcV[2])
    );

    typedef struct {
        string name;
        bit    r, c, e, u;
        int    h, l, co, bo, tc;
    } vec_t;

    vec_t vecs[$];

    // Drive one DUT's inputs away from the edge, then settle just after it.
    task automatic applyStimulus(input int d, input bit r, input bit c, input bit e, input bit u);
        @(negedge clk);
        rstV[d] = r;
        clrV[d] = c;
        enV[d]  = e;
        upV[d]  = u;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int d, input int eh, input int el,
                               input int eco, input int ebo, input int etc);
        checks++;
        if (int'(highV[d]) != eh || int'(lowV[d]) != el || int'(coV[d]) != eco ||
            int'(boV[d]) != ebo || int'(tcV[d]) != etc) begin
            failures++;
            $display("[TB] FAIL %s: got high=%0d low=%0d co=%0d bo=%0d tc=%0d, want high=%0d low=%0d co=%0d bo=%0d tc=%0d",
                     name, highV[d], lowV[d], coV[d], boV[d], tcV[d], eh, el, eco, ebo, etc);
        end
    endtask

    initial begin
        rstV = '0; clrV = '0; enV = '0; upV = '0;
`ifdef BCD_COUNTER_LOAD_EN
        load0 = 1'b0; loadLow0 = 4'd0; loadHigh0 = 4'd0;
`endif

        //                name            r  c  e  u   h  l co bo tc
        vecs.push_back('{"reset",        1, 0, 0, 0,  0, 0, 0, 0, 0});
        vecs.push_back('{"up1",          0, 0, 1, 1,  0, 1, 0, 0, 0});
        vecs.push_back('{"up2",          0, 0, 1, 1,  0, 2, 0, 0, 0});
        vecs.push_back('{"dirchg",       0, 0, 1, 0,  0, 1, 0, 0, 0});
        vecs.push_back('{"down0",        0, 0, 1, 0,  0, 0, 0, 0, 1});
        vecs.push_back('{"downwrap",     0, 0, 1, 0,  5, 9, 0, 1, 0});
        vecs.push_back('{"hold59",       0, 0, 0, 0,  5, 9, 0, 0, 0});
        vecs.push_back('{"upwrap",       0, 0, 1, 1,  0, 0, 1, 0, 0});
        vecs.push_back('{"holdpulse",    0, 0, 0, 1,  0, 0, 0, 0, 0});
        vecs.push_back('{"up1b",         0, 0, 1, 1,  0, 1, 0, 0, 0});
        vecs.push_back('{"clr",          0, 1, 1, 1,  0, 0, 0, 0, 0});
        vecs.push_back('{"downwrap2",    0, 0, 1, 0,  5, 9, 0, 1, 0});
        vecs.push_back('{"rst_at59",     1, 0, 1, 1,  0, 0, 0, 0, 0});
        vecs.push_back('{"downwrap3",    0, 0, 1, 0,  5, 9, 0, 1, 0});
        vecs.push_back('{"clr_at59",     0, 1, 1, 1,  0, 0, 0, 0, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(0, vecs[i].r, vecs[i].c, vecs[i].e, vecs[i].u);
            checkOutput(vecs[i].name, 0, vecs[i].h, vecs[i].l, vecs[i].co, vecs[i].bo, vecs[i].tc);
        end

        // Full up cycle on mod-60: carry only on the 59->0 edge, tc while showing 5/9.
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("cyc_reset", 0, 0, 0, 0, 0, 0);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(0, 0, 0, 1, 1);
            cnt = (cnt + 1) % 60;
            checkOutput($sformatf("cyc%0d", i), 0, cnt / 10, cnt % 10,
                        (cnt == 0) ? 1 : 0, 0, (cnt == 59) ? 1 : 0);
        end
        applyStimulus(0, 0, 0, 0, 1);

        // Mod-24 with INIT=12 holds 1/2 with en low.
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("m24_reset", 1, 1, 2, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 0, 1);
            checkOutput($sformatf("m24_hold%0d", i), 1, 1, 2, 0, 0, 0);
        end

        // Mod-100: climb to 99, wrap, then alternate direction every cycle.
        applyStimulus(2, 1, 0, 0, 0);
        checkOutput("m100_reset", 2, 0, 0, 0, 0, 0);
        for (int i = 0; i < 99; i++) applyStimulus(2, 0, 0, 1, 1);
        checkOutput("m100_at99", 2, 9, 9, 0, 0, 1);
        applyStimulus(2, 0, 0, 1, 1);
        checkOutput("m100_wrap", 2, 0, 0, 1, 0, 0);
        applyStimulus(2, 0, 0, 1, 0);
        checkOutput("m100_tgl_down", 2, 9, 9, 0, 1, 0);
        applyStimulus(2, 0, 0, 1, 1);
        checkOutput("m100_tgl_up", 2, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(2, 0, 0, 1, 1);
        checkOutput("m100_at5", 2, 0, 5, 0, 0, 0);
        cnt = 5;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2, 0, 0, 1, (i % 2 == 1));
            cnt = (i % 2 == 1) ? cnt + 1 : cnt - 1;
            checkOutput($sformatf("m100_alt%0d", i), 2, cnt / 10, cnt % 10, 0, 0, 0);
        end

`ifdef BCD_COUNTER_LOAD_EN
        // Parallel load on mod-60, including illegal values and load beating en.
        applyStimulus(0, 0, 0, 0, 1);
        @(negedge clk); load0 = 1'b1; loadHigh0 = 4'd4; loadLow0 = 4'd7;
        @(posedge clk); #1;
        checkOutput("load47", 0, 4, 7, 0, 0, 0);
        @(negedge clk); loadHigh0 = 4'd6; loadLow0 = 4'd3;
        @(posedge clk); #1;
        checkOutput("load63", 0, 0, 0, 0, 0, 0);
        @(negedge clk); loadHigh0 = 4'd1; loadLow0 = 4'hA;
        @(posedge clk); #1;
        checkOutput("loadA", 0, 0, 0, 0, 0, 0);
        @(negedge clk); loadHigh0 = 4'd2; loadLow0 = 4'd5; enV[0] = 1'b1; upV[0] = 1'b1;
        @(posedge clk); #1;
        checkOutput("load_en", 0, 2, 5, 0, 0, 0);
        @(negedge clk); load0 = 1'b0;
        @(posedge clk); #1;
        checkOutput("after_load", 0, 2, 6, 0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_mod_counter.md
BCD_MOD_COUNTER -- requirements
Module: bcd_mod_counter

Interface
REQ-001 SHALL provide parameter MODULUS, default 60: count modulus, legal range 2..100.
REQ-002 SHALL provide parameter INIT, default 0: value loaded on rst; legal range 0..MODULUS-1.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clkin and rst.
REQ-004 clkin  input  1  rising-edge clock; all state changes on this edge only.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 clr  input  1  synchronous clear to 0; low priority relative to rst.
REQ-007 en  input  1  count enable, cascade input.
REQ-008 up  input  1  direction: 1=increment, 0=decrement.
REQ-009 load  input  1  parallel load strobe (BCD_COUNTER_LOAD_EN only).
REQ-010 load_low  input  4  BCD units digit to load (BCD_COUNTER_LOAD_EN only).
REQ-011 load_high  input  4  BCD tens digit to load (BCD_COUNTER_LOAD_EN only).
REQ-012 low  output  4  registered BCD units digit of count.
REQ-013 high  output  4  registered BCD tens digit of count.
REQ-014 co  output  1  registered one-cycle carry pulse on up-wrap.
REQ-015 bo  output  1  registered one-cycle borrow pulse on down-wrap.
REQ-016 tc  output  1  combinational terminal count for ripple-free cascading.

Function
REQ-017 Internal binary count SHALL be 7 bits, always within 0..MODULUS-1.
REQ-018 Outputs SHALL satisfy low = count%10 and high = count/10 in the same cycle as count; no extra latency.
REQ-019 Per-edge priority SHALL be: rst > clr > load > en > hold.
REQ-020 en=1, up=1: count<MODULUS-1 -> count+1, co=0; count=MODULUS-1 -> count=0, co=1.
REQ-021 en=1, up=0: count>0 -> count-1, bo=0; count=0 -> count=MODULUS-1, bo=1.
REQ-022 en=0 with no higher-priority action: count SHALL hold; co=0 and bo=0.
REQ-023 co and bo SHALL be high for exactly one cycle per wrap and SHALL never be high together.
REQ-024 tc SHALL equal en & ((up & count==MODULUS-1) | (~up & count==0)).
REQ-025 clr SHALL force count=0, co=0, bo=0.
REQ-026 A direction change while en=1 SHALL take effect on the same edge, with no lost or extra step.
REQ-027 On load, if load_low<=9, load_high<=9 and 10*load_high+load_low<MODULUS, count SHALL take that value; otherwise count SHALL become 0. co=0 and bo=0 in both cases.

Reset
REQ-028 On rst=1 at a clkin edge, count SHALL become INIT, low/high SHALL show INIT, and co=0, bo=0.
REQ-029 rst asserted mid-count or coincident with a wrap SHALL suppress co/bo on that edge.
REQ-030 After power-up, outputs are undefined until the first rst edge.

Configuration
REQ-031 Macro BCD_COUNTER_LOAD_EN defined: load, load_low and load_high ports exist and REQ-027 applies.
REQ-032 Macro BCD_COUNTER_LOAD_EN undefined: those three ports are absent, no load logic is built, and all other behaviour is identical.

Verification
REQ-033 MODULUS=60, rst, then en=1, up=1 for 60 clocks -> high/low steps 0/0..5/9 then back to 0/0; co=1 on that edge only; tc=1 while at 5/9.
REQ-034 MODULUS=60, count=0, en=1, up=0 one clock -> high=5, low=9, bo=1 for one cycle, co=0.
REQ-035 MODULUS=24, INIT=12, rst then en=0 for 5 clocks -> output holds 1/2; co=0, bo=0, tc=0.
REQ-036 Load enabled, MODULUS=60: load 4/7 -> 4/7; load 6/3 -> 0/0; load_low=0xA -> 0/0; load with en=1 -> loaded value, no step.
REQ-037 At count 59 with en=1, up=1: rst on that edge -> INIT, co=0; clr on that edge -> 0/0, co=0.
REQ-038 MODULUS=100: count 99 -> 0 with co=1 while en=1, up=1; toggling up each cycle alternates ±1 with no lost step.
